// File: rtl/i2s_voice_scheduler_if.sv
// Voice-request and serializer-facing signals of the I2S voice scheduler.
// slave = scheduler side, master = requesters/serializer side.
interface i2s_voice_scheduler_if #(
    parameter int NUM_VOICES = 4
);
    logic                      en;
    logic [NUM_VOICES-1:0]     req_valid;
    logic [8*NUM_VOICES-1:0]   req_sample;
    logic [NUM_VOICES-1:0]     req_ready;
    logic                      sclk;
    logic                      lrclk;
    logic [7:0]                sample;
    logic                      sample_stb;
    logic [NUM_VOICES-1:0]     underrun;

    modport master (
        output en, req_valid, req_sample,
        input  req_ready, sclk, lrclk, sample, sample_stb, underrun
    );

    modport slave (
        input  en, req_valid, req_sample,
        output req_ready, sclk, lrclk, sample, sample_stb, underrun
    );
endinterface

// File: rtl/i2s_voice_scheduler.sv
// I2S sequencer: SCLK/LRCLK generation, one fetch per voice per frame, mixed sample out.
// Latency: SAMPLE updates NUM_VOICES+1 cycles after LRCLK rise. I2S_MIX_AVG_EN selects averaging mix.
// Backpressure: none; a voice not valid in its slot is skipped and flagged in UNDERRUN.
module i2s_voice_scheduler #(
    parameter int NUM_VOICES  = 4,
    parameter int SCLK_DIV    = 8,
    parameter int BITS_PER_CH = 32
) (
    input logic                    Clk,
    input logic                    Reset_n,
    i2s_voice_scheduler_if.slave   bus
);
    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = 8 + VW;
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(2 * BITS_PER_CH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MIX} state_t;

    state_t                 r_state, w_state_nxt;
    logic [DIV_W-1:0]       r_div_cnt, w_div_nxt;
    logic [BIT_W-1:0]       r_bit_cnt, w_bit_nxt;
    logic                   w_div_wrap, w_lr_rise;
    logic                   r_sclk, r_lrclk;
    logic [VW-1:0]          r_vidx;
    logic [ACC_W-1:0]       r_acc, w_acc_nxt, w_smp_ext;
    logic                   w_cur_vld, w_last;
    logic [7:0]             w_cur_smp, w_mix;
    logic [7:0]             r_sample;
    logic                   r_sample_stb;
    logic [NUM_VOICES-1:0]  r_underrun, w_req_ready;

    always_comb begin
        w_div_wrap = (r_div_cnt == DIV_W'(SCLK_DIV - 1));
        w_div_nxt  = w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
        w_bit_nxt  = r_bit_cnt;
        if (w_div_wrap)
            w_bit_nxt = (r_bit_cnt == BIT_W'(2 * BITS_PER_CH - 1)) ? '0 : r_bit_cnt + BIT_W'(1);
        w_lr_rise  = (r_bit_cnt == BIT_W'(BITS_PER_CH)) && (r_div_cnt == '0);
    end

    always_comb begin
        w_cur_vld = bus.req_valid[r_vidx];
        w_cur_smp = bus.req_sample[{r_vidx, 3'b000} +: 8];
        w_smp_ext = {{VW{w_cur_smp[7]}}, w_cur_smp};
        w_acc_nxt = w_cur_vld ? r_acc + w_smp_ext : r_acc;
        w_last    = (r_vidx == VW'(NUM_VOICES - 1));
    end

`ifdef I2S_MIX_AVG_EN
    // Dropping the low VW bits of a two's complement sum is a floor divide by NUM_VOICES.
    assign w_mix = w_acc_nxt[VW +: 8];
`else
    logic [ACC_W-8:0] w_hi;
    logic             w_fits;
    always_comb begin
        w_hi   = w_acc_nxt[ACC_W-1:7];
        w_fits = (&w_hi) | ~(|w_hi);
        w_mix  = w_fits ? w_acc_nxt[7:0] : (w_acc_nxt[ACC_W-1] ? 8'h80 : 8'h7F);
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        case (r_state)
            S_IDLE:  if (w_lr_rise) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (w_cur_vld) w_req_ready[r_vidx] = 1'b1;
                if (w_last)    w_state_nxt = S_MIX;
            end
            S_MIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (!bus.en) begin
            w_state_nxt = S_IDLE;
            w_req_ready = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_lrclk      <= 1'b0;
            r_vidx       <= '0;
            r_acc        <= '0;
            r_sample     <= '0;
            r_sample_stb <= 1'b0;
            r_underrun   <= '0;
        end else if (!bus.en) begin
            // Idle: drop any partial frame; underrun flags keep their last value.
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_lrclk      <= 1'b0;
            r_vidx       <= '0;
            r_acc        <= '0;
            r_sample     <= '0;
            r_sample_stb <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_sclk       <= (w_div_nxt >= DIV_W'(SCLK_DIV / 2));
            r_lrclk      <= (w_bit_nxt >= BIT_W'(BITS_PER_CH));
            r_sample_stb <= 1'b0;
            case (r_state)
                S_IDLE: if (w_lr_rise) begin
                    r_acc  <= '0;
                    r_vidx <= '0;
                end
                S_FETCH: begin
                    r_acc              <= w_acc_nxt;
                    r_underrun[r_vidx] <= ~w_cur_vld;
                    r_vidx             <= r_vidx + VW'(1);
                    if (w_last) begin
                        r_sample     <= w_mix;
                        r_sample_stb <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.sclk       = r_sclk;
    assign bus.lrclk      = r_lrclk;
    assign bus.sample     = r_sample;
    assign bus.sample_stb = r_sample_stb;
    assign bus.underrun   = r_underrun;
endmodule

// File: tb/tb_i2s_voice_scheduler.sv
// Bench for i2s_voice_scheduler: frame-phase reference model checked every cycle,
// plus directed literal checks. Honours I2S_MIX_AVG_EN for the mix expectation.
module tb_i2s_voice_scheduler;
    localparam int NV    = 4;
    localparam int LOGV  = 2;
    localparam int FRAME = 512;
    localparam int RISE  = 256;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    i2s_voice_scheduler_if #(.NUM_VOICES(NV)) ifc();

    i2s_voice_scheduler #(.NUM_VOICES(NV), .SCLK_DIV(8), .BITS_PER_CH(32)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (ifc.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mix(input int s);
`ifdef I2S_MIX_AVG_EN
        int a;
        a = s >>> LOGV;
        return a[7:0];
`else
        int c;
        c = (s > 127) ? 127 : ((s < -128) ? -128 : s);
        return c[7:0];
`endif
    endfunction

    // Reference model: mk = Clk cycles since the run (re)started with counters at zero.
    int          mk = 0;
    logic [NV-1:0] m_under = '0;
    logic [7:0]  m_sample = '0;
    logic        m_stb = 1'b0;
    int          m_acc = 0;
    int          rdy_cnt = 0;
    int          rdy_phase = -1;

    initial begin
        int p, v;
        logic [NV-1:0] exp_rdy;
        forever begin
            @(posedge Clk);
            if (!Reset_n) begin
                mk = 0; m_under = '0; m_sample = '0; m_stb = 1'b0;
            end else if (!ifc.en) begin
                mk = 0; m_sample = '0; m_stb = 1'b0;
            end else begin
                p = mk % FRAME;
                m_stb = 1'b0;
                if (p == RISE) m_acc = 0;
                if (p > RISE && p <= RISE + NV) begin
                    v = p - RISE - 1;
                    if (ifc.req_valid[v]) m_acc += int'($signed(ifc.req_sample[8*v +: 8]));
                    m_under[v] = !ifc.req_valid[v];
                    if (v == NV - 1) begin
                        m_sample = mix(m_acc);
                        m_stb    = 1'b1;
                    end
                end
                mk++;
            end
            @(negedge Clk);
            if (!Reset_n) begin
                mk = 0; m_under = '0; m_sample = '0; m_stb = 1'b0;
            end
            p = mk % FRAME;
            exp_rdy = '0;
            if (Reset_n && ifc.en && p > RISE && p <= RISE + NV && ifc.req_valid[p-RISE-1])
                exp_rdy[p-RISE-1] = 1'b1;
            if (p == 0) rdy_cnt = 0;
            if (ifc.req_ready != '0) begin
                rdy_cnt++;
                rdy_phase = p;
            end
            chk("sclk",       32'(ifc.sclk),       32'((mk % 8) >= 4));
            chk("lrclk",      32'(ifc.lrclk),      32'(((mk / 8) % 64) >= 32));
            chk("req_ready",  32'(ifc.req_ready),  32'(exp_rdy));
            chk("sample",     32'(ifc.sample),     32'(m_sample));
            chk("sample_stb", 32'(ifc.sample_stb), 32'(m_stb));
            chk("underrun",   32'(ifc.underrun),   32'(m_under));
        end
    end

    task automatic wait_neg(input int ph);
        int n;
        for (n = 0; n < 2 * FRAME + 10; n++) begin
            @(negedge Clk);
            if ((mk % FRAME) == ph) break;
        end
        if (n >= 2 * FRAME + 10) begin
            n_vec++; n_err++;
            $display("FAIL wait_phase: phase %0d not reached, got %0d expected %0d", ph, mk % FRAME, ph);
        end
    endtask

    // Returns at posedge+2 of the cycle whose frame phase is ph.
    task automatic goto(input int ph);
        wait_neg((ph - 1 + FRAME) % FRAME);
        @(posedge Clk);
        #2;
    endtask

    task automatic set_v(input logic [NV-1:0] m, input logic [8*NV-1:0] s);
        ifc.req_valid  = m;
        ifc.req_sample = s;
    endtask

    task automatic frame(input logic [NV-1:0] m, input logic [8*NV-1:0] s,
                         input logic [7:0] e_sum, input logic [7:0] e_avg, input string nm);
        goto(0);
        set_v(m, s);
        wait_neg(RISE + NV + 2);
`ifdef I2S_MIX_AVG_EN
        chk(nm, 32'(ifc.sample), 32'(e_avg));
`else
        chk(nm, 32'(ifc.sample), 32'(e_sum));
`endif
    endtask

    initial begin
        int lr_hi, sc_rise, grants, n;
        logic prev_sclk;
        ifc.en = 1'b0;
        set_v('0, '0);
        repeat (3) @(posedge Clk);
        #2;
        chk("rst_sample",   32'(ifc.sample),   32'h0);
        chk("rst_underrun", 32'(ifc.underrun), 32'h0);
        chk("rst_lrclk",    32'(ifc.lrclk),    32'h0);
        Reset_n = 1'b1;
        ifc.en  = 1'b1;

        // Idle voices: clock shape over the first frame, all underrun after the first fetch.
        lr_hi = 0; sc_rise = 0; grants = 0; prev_sclk = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge Clk);
            lr_hi += int'(ifc.lrclk);
            if (ifc.sclk && !prev_sclk) sc_rise++;
            prev_sclk = ifc.sclk;
            if (ifc.req_ready != '0) grants++;
            if (i == RISE + NV + 1) begin
                chk("t1_underrun", 32'(ifc.underrun), 32'hF);
                chk("t1_sample",   32'(ifc.sample),   32'h0);
            end
        end
        chk("t1_lrclk_high", lr_hi, 256);
        chk("t1_sclk_rises", sc_rise, 64);
        chk("t1_grants", grants, 0);

        frame(4'b0100, 32'h0040_0000, 8'h40, 8'h10, "t2_single");
        chk("t2_ready_cycles", rdy_cnt, 1);
        chk("t2_ready_phase", rdy_phase, RISE + 3);
        chk("t2_underrun", 32'(ifc.underrun), 32'hB);

        frame(4'b0011, 32'h0000_5050, 8'h7F, 8'h28, "t3_pos_sat");
        frame(4'b0011, 32'h0000_E050, 8'h30, 8'h0C, "t3_mixed_sign");
        frame(4'b1111, 32'h8080_8080, 8'h80, 8'h80, "t3_neg_sat");
        frame(4'b1111, 32'h7F7F_7F7F, 8'h7F, 8'h7F, "t4_all_max");
        frame(4'b1111, 32'hF010_1010, 8'h20, 8'h08, "t4_small_sum");

        // Voice 0 raises valid after its slot: skipped this frame, taken next frame.
        goto(0);
        set_v(4'b0000, 32'h0000_0011);
        goto(RISE + 2);
        ifc.req_valid = 4'b0001;
        wait_neg(RISE + NV + 2);
        chk("late_sample", 32'(ifc.sample), 32'h0);
        chk("late_underrun0", 32'(ifc.underrun[0]), 32'h1);
        wait_neg(RISE + NV + 2);
`ifdef I2S_MIX_AVG_EN
        chk("late_next_frame", 32'(ifc.sample), 32'h04);
`else
        chk("late_next_frame", 32'(ifc.sample), 32'h11);
`endif

        // EN dropped while voice 1 is being fetched.
        goto(0);
        set_v(4'b1111, 32'h0403_0201);
        goto(RISE + 2);
        ifc.en = 1'b0;
        @(posedge Clk);
        #1;
        chk("t5_sclk",   32'(ifc.sclk),      32'h0);
        chk("t5_lrclk",  32'(ifc.lrclk),     32'h0);
        chk("t5_sample", 32'(ifc.sample),    32'h0);
        chk("t5_ready",  32'(ifc.req_ready), 32'h0);
        repeat (5) @(posedge Clk);
        #2;
        ifc.en = 1'b1;
        for (n = 0; n < 700; n++) begin
            @(posedge Clk);
            #1;
            if (ifc.req_ready != '0) break;
        end
        chk("t5_first_grant_delay", n + 1, 257);
        chk("t5_first_grant", 32'(ifc.req_ready), 32'h1);

        // Asynchronous reset mid-frame, between clock edges.
        goto(300);
`ifdef I2S_MIX_AVG_EN
        chk("t6_pre_sample", 32'(ifc.sample), 32'h02);
`else
        chk("t6_pre_sample", 32'(ifc.sample), 32'h0A);
`endif
        #1;
        Reset_n = 1'b0;
        #1;
        chk("t6_sclk",     32'(ifc.sclk),     32'h0);
        chk("t6_lrclk",    32'(ifc.lrclk),    32'h0);
        chk("t6_sample",   32'(ifc.sample),   32'h0);
        chk("t6_underrun", 32'(ifc.underrun), 32'h0);
        repeat (3) @(posedge Clk);
        #2;
        Reset_n = 1'b1;

        for (int f = 0; f < 20; f++) begin
            goto(0);
            set_v(4'($urandom), $urandom);
        end
        wait_neg(RISE + NV + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
